// File: rtl/loop_pred_pkg.sv
// -----------------------------------------------------------------------------
// loop_pred_pkg
// Shared types and helpers for the loop trip-count predictor.
//   loop_entry_t : one table entry (valid, tag, trip, commit_iter, spec_iter,
//                  conf). The field widths are fixed here so the table, the
//                  update logic and the top all agree on a single entry layout.
//   idx_w()      : index width for a given table size.
//   tag_of()     : tag bits, taken from just above the index.
//   CONF_MAX     : confidence level at which predictions are enabled.
// -----------------------------------------------------------------------------
package loop_pred_pkg;

    localparam int TAG_W  = 8;
    localparam int CNT_W  = 10;
    localparam int CONF_W = 2;

    localparam logic [CONF_W-1:0] CONF_MAX = '1;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [CNT_W-1:0]  trip;
        logic [CNT_W-1:0]  commit_iter;
        logic [CNT_W-1:0]  spec_iter;
        logic [CONF_W-1:0] conf;
    } loop_entry_t;

    function automatic int idx_w(input int entries);
        return $clog2(entries);
    endfunction

    // PC bits [1:0] are the instruction alignment and the index sits above
    // them, so the tag starts at bit idx_bits+2.
    function automatic logic [TAG_W-1:0] tag_of(input logic [63:0] pc,
                                                input int          idx_bits);
        return TAG_W'(pc >> (idx_bits + 2));
    endfunction

endpackage

// File: rtl/loop_predictor_if.sv
// -----------------------------------------------------------------------------
// loop_predictor_if
// Fetch-lookup and execute-training signals of the loop predictor.
//   PC_F, branch_en_F                 : fetch-stage lookup request
//   PC_EX, PC_destination_EX,
//   branch_en_EX, feedback_from_ALU   : resolved conditional branch in EX
//   flush_EX                          : EX misprediction flush
//   LD_en, loop_decision              : override valid / predicted direction
// master drives the requests (pipeline side), slave is the predictor.
// -----------------------------------------------------------------------------
interface loop_predictor_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] PC_F;
    logic             branch_en_F;
    logic [WIDTH-1:0] PC_EX;
    logic [WIDTH-1:0] PC_destination_EX;
    logic             branch_en_EX;
    logic             feedback_from_ALU;
    logic             flush_EX;
    logic             LD_en;
    logic             loop_decision;

    modport master (
        output PC_F, branch_en_F, PC_EX, PC_destination_EX,
               branch_en_EX, feedback_from_ALU, flush_EX,
        input  LD_en, loop_decision
    );

    modport slave (
        input  PC_F, branch_en_F, PC_EX, PC_destination_EX,
               branch_en_EX, feedback_from_ALU, flush_EX,
        output LD_en, loop_decision
    );
endinterface

// File: rtl/loop_pred_update.sv
// -----------------------------------------------------------------------------
// loop_pred_update
// Combinational next-entry logic for a backward branch resolving in EX.
//   active : backward conditional branch valid in EX
//   taken  : resolved direction
//   tag    : tag of the EX PC
//   cur    : current entry at the EX index (already carrying any same-cycle
//            fetch update of spec_iter)
//   nxt    : entry to write back (train on hit, allocate or age on miss)
// -----------------------------------------------------------------------------
module loop_pred_update
    import loop_pred_pkg::*;
(
    input  logic             active,
    input  logic             taken,
    input  logic [TAG_W-1:0] tag,
    input  loop_entry_t      cur,
    output loop_entry_t      nxt
);

    logic             hit;
    logic [CNT_W-1:0] observed;

    always_comb begin
        hit      = cur.valid && (cur.tag == tag);
        observed = cur.commit_iter + 1'b1;
        nxt      = cur;

        if (active) begin
            if (hit) begin
                if (taken) begin
                    // A loop longer than the counter can hold is unusable.
                    if (cur.commit_iter == '1) begin
                        nxt.valid = 1'b0;
                    end else begin
                        nxt.commit_iter = cur.commit_iter + 1'b1;
                    end
                end else begin
                    if (observed == cur.trip) begin
                        if (cur.conf != CONF_MAX) begin
                            nxt.conf = cur.conf + 1'b1;
                        end
                    end else begin
                        nxt.trip = observed;
                        nxt.conf = '0;
                    end
                    nxt.commit_iter = '0;
                end
                // Until the loop is confident, fetch is not running ahead on
                // its own, so keep the speculative count locked to EX.
                if (cur.conf != CONF_MAX) begin
                    nxt.spec_iter = nxt.commit_iter;
                end
            end else if (taken) begin
                // Only displace an entry that has lost all confidence;
                // otherwise wear it down so a persistent newcomer wins later.
                if (!cur.valid || (cur.conf == '0)) begin
                    nxt.valid       = 1'b1;
                    nxt.tag         = tag;
                    nxt.trip        = '0;
                    nxt.conf        = '0;
                    nxt.commit_iter = CNT_W'(1);
                    nxt.spec_iter   = CNT_W'(1);
                end else begin
                    nxt.conf = cur.conf - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/loop_predictor.sv
// -----------------------------------------------------------------------------
// loop_predictor
// Tagged loop trip-count predictor. Learns the iteration count of backward
// conditional branches at EX and, once confident, overrides the base
// predictor at F with an exact taken/exit prediction.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : loop_predictor_if.slave (F lookup, EX training, flush, outputs)
// -----------------------------------------------------------------------------
module loop_predictor
    import loop_pred_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int ENTRIES = 64
) (
    input  logic            clk,
    input  logic            rst,
    loop_predictor_if.slave bus
);

    localparam int IDX_W = idx_w(ENTRIES);

    loop_entry_t      table_q [ENTRIES];
    loop_entry_t      table_d [ENTRIES];

    logic [WIDTH-1:0] pc_f, pc_ex, pc_dst_ex;
    logic [IDX_W-1:0] f_idx, ex_idx;
    logic [TAG_W-1:0] f_tag, ex_tag;
    loop_entry_t      f_ent, ex_cur, ex_nxt;
    logic             f_hit, f_ld_en, f_taken, ex_active;
    logic [CNT_W-1:0] f_spec_next;

    assign pc_f      = bus.PC_F;
    assign pc_ex     = bus.PC_EX;
    assign pc_dst_ex = bus.PC_destination_EX;

    assign f_idx  = pc_f[IDX_W+1:2];
    assign ex_idx = pc_ex[IDX_W+1:2];
    assign f_tag  = tag_of(64'(pc_f), IDX_W);
    assign ex_tag = tag_of(64'(pc_ex), IDX_W);

    // Fetch lookup. The +1 compare is widened by a bit so an all-ones
    // spec_iter cannot wrap around and falsely match.
    always_comb begin
        f_ent       = table_q[f_idx];
        f_hit       = f_ent.valid && (f_ent.tag == f_tag);
        f_ld_en     = f_hit && bus.branch_en_F && (f_ent.conf == CONF_MAX)
                      && (f_ent.trip != '0);
        f_taken     = f_ld_en
                      && (({1'b0, f_ent.spec_iter} + 1'b1) != {1'b0, f_ent.trip});
        f_spec_next = f_taken ? (f_ent.spec_iter + 1'b1) : '0;
    end

    assign bus.LD_en         = f_ld_en;
    assign bus.loop_decision = f_taken;

    assign ex_active = bus.branch_en_EX && (pc_dst_ex < pc_ex);

    // The EX update sees the fetch increment first so that, when it does not
    // resync spec_iter itself, the fetch-side progress is preserved.
    always_comb begin
        ex_cur = table_q[ex_idx];
        if (f_ld_en && (f_idx == ex_idx)) begin
            ex_cur.spec_iter = f_spec_next;
        end
    end

    loop_pred_update u_update (
        .active (ex_active),
        .taken  (bus.feedback_from_ALU),
        .tag    (ex_tag),
        .cur    (ex_cur),
        .nxt    (ex_nxt)
    );

    // Layered writes give the spec_iter priority flush > EX > fetch, while
    // EX owns trip, conf and commit_iter outright.
    always_comb begin
        table_d = table_q;
        if (f_ld_en) begin
            table_d[f_idx].spec_iter = f_spec_next;
        end
        table_d[ex_idx] = ex_nxt;
        if (bus.flush_EX) begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (table_d[i].valid) begin
                    table_d[i].spec_iter = table_d[i].commit_iter;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= '0;
            end
        end else begin
            table_q <= table_d;
        end
    end

endmodule

// File: tb/tb_loop_predictor.sv
// -----------------------------------------------------------------------------
// tb_loop_predictor
// Directed scenarios followed by randomized loop traffic for loop_predictor,
// compared every cycle against a behavioural table model kept in this file.
// -----------------------------------------------------------------------------
module tb_loop_predictor;

    localparam int NENT     = 64;
    localparam int CNT_MOD  = 1024;
    localparam int CONF_TOP = 3;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    loop_predictor_if #(.WIDTH(32)) bus ();

    loop_predictor #(.WIDTH(32), .ENTRIES(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int nAssert = 0;
    int nFail   = 0;

    // Behavioural model: one record per table slot, plain integers.
    bit mValid  [NENT];
    int mTag    [NENT];
    int mTrip   [NENT];
    int mCommit [NENT];
    int mSpec   [NENT];
    int mConf   [NENT];

    function automatic int idxOf(input logic [31:0] pc);
        return int'((pc >> 2) % NENT);
    endfunction

    function automatic int tagOf(input logic [31:0] pc);
        return int'((pc >> 8) % 256);
    endfunction

    function automatic bit modelLd(input logic [31:0] pc, input logic bf);
        int i;
        i = idxOf(pc);
        return bf && mValid[i] && (mTag[i] == tagOf(pc))
               && (mConf[i] == CONF_TOP) && (mTrip[i] != 0);
    endfunction

    function automatic bit modelDec(input logic [31:0] pc, input logic bf);
        int i;
        i = idxOf(pc);
        return modelLd(pc, bf) && ((mSpec[i] + 1) != mTrip[i]);
    endfunction

    task automatic modelReset();
        for (int i = 0; i < NENT; i++) begin
            mValid[i] = 0; mTag[i] = 0; mTrip[i] = 0;
            mCommit[i] = 0; mSpec[i] = 0; mConf[i] = 0;
        end
    endtask

    // One clock of table evolution: fetch advance, then EX training, then flush.
    task automatic modelStep();
        int fi, ei, et, oldConf, obs;
        bit ld, dec;
        fi  = idxOf(bus.PC_F);
        ld  = modelLd(bus.PC_F, bus.branch_en_F);
        dec = modelDec(bus.PC_F, bus.branch_en_F);
        if (ld) mSpec[fi] = dec ? (mSpec[fi] + 1) % CNT_MOD : 0;

        if (bus.branch_en_EX && (bus.PC_destination_EX < bus.PC_EX)) begin
            ei = idxOf(bus.PC_EX);
            et = tagOf(bus.PC_EX);
            if (mValid[ei] && (mTag[ei] == et)) begin
                oldConf = mConf[ei];
                if (bus.feedback_from_ALU) begin
                    if (mCommit[ei] == CNT_MOD - 1) mValid[ei] = 0;
                    else mCommit[ei] = mCommit[ei] + 1;
                end else begin
                    obs = (mCommit[ei] + 1) % CNT_MOD;
                    if (obs == mTrip[ei]) begin
                        if (mConf[ei] < CONF_TOP) mConf[ei] = mConf[ei] + 1;
                    end else begin
                        mTrip[ei] = obs;
                        mConf[ei] = 0;
                    end
                    mCommit[ei] = 0;
                end
                if (oldConf < CONF_TOP) mSpec[ei] = mCommit[ei];
            end else if (bus.feedback_from_ALU) begin
                if (!mValid[ei] || (mConf[ei] == 0)) begin
                    mValid[ei] = 1; mTag[ei] = et; mTrip[ei] = 0;
                    mConf[ei] = 0; mCommit[ei] = 1; mSpec[ei] = 1;
                end else begin
                    mConf[ei] = mConf[ei] - 1;
                end
            end
        end

        if (bus.flush_EX) begin
            for (int i = 0; i < NENT; i++) begin
                if (mValid[i]) mSpec[i] = mCommit[i];
            end
        end
    endtask

    // Compare outputs with the model; optionally also with a fixed value
    // worked out by hand for the directed scenarios (negative = none).
    task automatic checkOutput(input string name, input int expLd, input int expDec);
        bit mLd, mDec;
        mLd  = modelLd(bus.PC_F, bus.branch_en_F);
        mDec = modelDec(bus.PC_F, bus.branch_en_F);
        nAssert++;
        assert (bus.LD_en === mLd) else begin
            nFail++;
            $error("[TB] FAIL %s LD_en observed=%0b expected=%0b", name, bus.LD_en, mLd);
        end
        nAssert++;
        assert (bus.loop_decision === mDec) else begin
            nFail++;
            $error("[TB] FAIL %s loop_decision observed=%0b expected=%0b", name, bus.loop_decision, mDec);
        end
        if (expLd >= 0) begin
            nAssert++;
            assert (bus.LD_en === 1'(expLd)) else begin
                nFail++;
                $error("[TB] FAIL %s LD_en(directed) observed=%0b expected=%0d", name, bus.LD_en, expLd);
            end
        end
        if (expDec >= 0) begin
            nAssert++;
            assert (bus.loop_decision === 1'(expDec)) else begin
                nFail++;
                $error("[TB] FAIL %s loop_decision(directed) observed=%0b expected=%0d", name, bus.loop_decision, expDec);
            end
        end
    endtask

    // Drive one cycle, check mid-cycle, advance the model on the clock edge.
    task automatic applyStimulus(input logic [31:0] pcF, input logic bF,
                                 input logic [31:0] pcEx, input logic [31:0] dstEx,
                                 input logic bEx, input logic tk, input logic fl,
                                 input int expLd, input int expDec, input string name);
        bus.PC_F              = pcF;
        bus.branch_en_F       = bF;
        bus.PC_EX             = pcEx;
        bus.PC_destination_EX = dstEx;
        bus.branch_en_EX      = bEx;
        bus.feedback_from_ALU = tk;
        bus.flush_EX          = fl;
        @(negedge clk);
        checkOutput(name, expLd, expDec);
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic exStep(input logic [31:0] pc, input logic [31:0] dst,
                          input logic tk, input string name);
        applyStimulus(32'h0, 1'b0, pc, dst, 1'b1, tk, 1'b0, -1, -1, name);
    endtask

    task automatic exVisit(input logic [31:0] pc, input logic [31:0] dst, input int nTaken);
        for (int k = 0; k < nTaken; k++) exStep(pc, dst, 1'b1, "ex_taken");
        exStep(pc, dst, 1'b0, "ex_exit");
    endtask

    task automatic fLook(input logic [31:0] pc, input int expLd, input int expDec,
                         input string name);
        applyStimulus(pc, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, expLd, expDec, name);
    endtask

    task automatic idleFlush(input string name);
        applyStimulus(32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, -1, -1, name);
    endtask

    logic [31:0] poolPc [6];
    int          trips  [6];
    int          expSeq [5];
    int          cur, remain;
    logic [31:0] rPcF, rPcEx, rDst;
    logic        rBF, rBEx, rTk, rFl;

    initial begin
        poolPc = '{32'h100, 32'h200, 32'h104, 32'h304, 32'h108, 32'h40C};
        expSeq = '{1, 1, 1, 1, 0};

        rst                   = 1'b1;
        bus.PC_F              = 32'h100;
        bus.branch_en_F       = 1'b1;
        bus.PC_EX             = 32'h0;
        bus.PC_destination_EX = 32'h0;
        bus.branch_en_EX      = 1'b0;
        bus.feedback_from_ALU = 1'b0;
        bus.flush_EX          = 1'b0;
        modelReset();
        #2;
        checkOutput("reset_hold", 0, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        fLook(32'h100, 0, 0, "post_reset_miss");

        // Training: four visits of 4 taken + exit make trip=5, conf=3.
        for (int v = 0; v < 4; v++) exVisit(32'h100, 32'hF0, 4);
        for (int i = 0; i < 5; i++) fLook(32'h100, 1, expSeq[i], "train_pred");
        exVisit(32'h100, 32'hF0, 4);

        // Trip change to 7 drops confidence.
        exVisit(32'h100, 32'hF0, 6);
        fLook(32'h100, 0, 0, "trip_change");

        // Forward branch at the same index must not disturb the entry.
        for (int k = 0; k < 4; k++) exStep(32'h200, 32'h240, 1'b1, "forward");
        fLook(32'h200, 0, 0, "forward_no_alloc");

        // Alias: retrain 0x100 (trip 7), then age it out with 0x200.
        for (int v = 0; v < 3; v++) exVisit(32'h100, 32'hF0, 6);
        fLook(32'h100, 1, 1, "alias_confident");
        exStep(32'h200, 32'h1F0, 1'b1, "age1");
        fLook(32'h100, 0, 0, "aged_once");
        exStep(32'h200, 32'h1F0, 1'b1, "age2");
        exStep(32'h200, 32'h1F0, 1'b1, "age3");
        exStep(32'h200, 32'h1F0, 1'b1, "replace");
        fLook(32'h100, 0, 0, "alias_replaced");
        fLook(32'h200, 0, 0, "alias_new_unconfident");

        // Flush: F two iterations ahead, then flush resyncs to commit (0).
        for (int v = 0; v < 4; v++) exVisit(32'h104, 32'hF0, 4);
        fLook(32'h104, 1, 1, "ahead1");
        fLook(32'h104, 1, 1, "ahead2");
        idleFlush("flush");
        for (int i = 0; i < 3; i++) fLook(32'h104, 1, 1, "after_flush");
        applyStimulus(32'h104, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1, 1, "flush_with_hit");
        for (int i = 0; i < 5; i++) fLook(32'h104, 1, expSeq[i], "flush_resume");

        // Reset in the middle of activity clears everything at once.
        applyStimulus(32'h104, 1'b1, 32'h10C, 32'hF0, 1'b1, 1'b1, 1'b0, 1, 1, "mid_train1");
        applyStimulus(32'h104, 1'b1, 32'h10C, 32'hF0, 1'b1, 1'b1, 1'b0, 1, 1, "mid_train2");
        bus.branch_en_EX = 1'b0;
        @(negedge clk);
        checkOutput("pre_reset", 1, 1);
        #1;
        rst = 1'b1;
        modelReset();
        #1;
        checkOutput("reset_immediate", 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        fLook(32'h104, 0, 0, "first_after_reset");

        // Randomized loop traffic over aliasing branches.
        for (int i = 0; i < 6; i++) trips[i] = int'($urandom_range(1, 5));
        cur    = 0;
        remain = trips[0] - 1;
        for (int c = 0; c < 3000; c++) begin
            rPcF  = poolPc[$urandom_range(0, 5)];
            rBF   = ($urandom_range(0, 3) != 0);
            rFl   = ($urandom_range(0, 19) == 0);
            rBEx  = 1'b0;
            rTk   = 1'b0;
            rPcEx = 32'h0;
            rDst  = 32'h0;
            if ($urandom_range(0, 9) == 0) begin
                rPcEx = poolPc[$urandom_range(0, 5)];
                rDst  = rPcEx + 32'h40;
                rBEx  = 1'b1;
                rTk   = 1'($urandom_range(0, 1));
            end else if ($urandom_range(0, 3) != 0) begin
                rPcEx = poolPc[cur];
                rDst  = rPcEx - 32'h10;
                rBEx  = 1'b1;
                rTk   = (remain > 0);
                if (remain > 0) begin
                    remain--;
                end else begin
                    cur = int'($urandom_range(0, 5));
                    if ($urandom_range(0, 7) == 0) trips[cur] = int'($urandom_range(1, 6));
                    remain = trips[cur] - 1;
                end
            end
            applyStimulus(rPcF, rBF, rPcEx, rDst, rBEx, rTk, rFl, -1, -1, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule

// File: doc/loop_predictor.md
# loop_predictor

Parametrised, tagged loop-trip-count predictor for the branch prediction unit. It learns the iteration count of backward conditional branches and overrides the base direction predictor with an exact exit prediction once a loop's trip count has been confirmed repeatedly. Lookup runs combinationally at fetch (F); training runs at execute (EX) from the ALU's resolved outcome. Speculative iteration state is rolled back on pipeline flush.

## Interface
- WIDTH, 32: PC width.
- ENTRIES, 64: table entries; power of two, 8..256.
- TAG_W, 8: tag bits per entry.
- CNT_W, 10: iteration counter / trip-count width.
- CONF_W, 2: confidence counter width. Prediction is enabled at all-ones.

- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- PC_F  in  WIDTH  fetch PC.
- branch_en_F  in  1  fetched instruction is a conditional branch.
- PC_EX  in  WIDTH  PC of the branch resolving in EX.
- PC_destination_EX  in  WIDTH  resolved target of that branch.
- branch_en_EX  in  1  conditional branch valid in EX.
- feedback_from_ALU  in  1  EX branch taken.
- flush_EX  in  1  EX misprediction flush.
- LD_en  out  1  F hit on a confident entry; the override is valid.
- loop_decision  out  1  predicted direction; 0 whenever LD_en=0.

## Operation
- Index is PC[IDX_W+1:2], with IDX_W=log2(ENTRIES). Tag is the next TAG_W bits above the index.
- Each entry holds valid, tag, trip (CNT_W), commit_iter (CNT_W), spec_iter (CNT_W) and conf (CONF_W).
- Backward test: PC_destination_EX < PC_EX, unsigned. Forward branches never allocate and never train.
- **F lookup**
  - Hit means valid and tag match.
  - LD_en = hit & branch_en_F & (conf == all-ones) & (trip != 0).
  - loop_decision = LD_en & (spec_iter + 1 != trip).
  - When LD_en=1: if the prediction is taken, spec_iter increments. If the prediction is exit, spec_iter is cleared.
- **EX hit, backward**
  - Taken: commit_iter++. If commit_iter is already all-ones, the entry is invalidated (loop too long).
  - Not taken: observed count = commit_iter + 1.
    - If observed == trip, conf increments, saturating.
    - Otherwise trip = observed and conf = 0.
    - In both cases commit_iter = 0.
  - While conf < all-ones (before this update), spec_iter is written with the new commit_iter.
- **EX miss, backward taken**
  - If the victim is invalid or has conf == 0: allocate. Set valid=1, new tag, trip=0, conf=0, commit_iter=spec_iter=1.
  - Otherwise decrement the victim's conf (aging) and do not allocate.
- EX miss, not taken: no action.
- flush_EX: every valid entry sets spec_iter = commit_iter, applied after that cycle's EX update.
- Same-cycle conflicts on one entry:
  - EX update of trip, conf and commit_iter wins.
  - For spec_iter, the priority is flush, then EX resync, then F increment.

## Timing
- Lookup has zero latency: LD_en and loop_decision are combinational from PC_F and the table.
- Updates are written on the clk rising edge and are visible to F lookups in the next cycle.
- Reset: all valid, conf and counters are cleared. LD_en=0 and loop_decision=0 immediately, with no clock needed.
- rst asserted mid-loop discards all state. There is no partial retention.
- Counter arithmetic is modulo 2^CNT_W, with the saturation and invalidation rules above. The spec_iter+1 compare is done at CNT_W+1 bits, so it does not wrap.

## Structure
- Package loop_pred_pkg holds:
  - the loop_entry_t struct (valid, tag, trip, commit_iter, spec_iter, conf);
  - the IDX_W and tag-slice helper functions;
  - the CONF_MAX constant.
- Sub-module loop_pred_update: combinational EX next-entry logic (train, allocate, age).
- The table, F lookup and flush resync live in the top module.

## Test plan
All scenarios use the defaults (ENTRIES=64, CONF_W=2).
- **Reset:** rst pulsed mid-training -> LD_en=0 and loop_decision=0 at once. The first lookup after release misses.
- **Training:** branch at PC=0x100, target 0x0F0, four visits of 4 taken + 1 not-taken -> after the 4th exit, trip=5, conf=3, LD_en=1. The 5th visit's F predictions are 1,1,1,1,0.
- **Trip change:** trained trip=5, then a visit of 7 -> at that exit conf=0, trip=7. LD_en=0 next cycle.
- **Forward branch:** PC=0x200, target 0x240, taken repeatedly -> no allocation, LD_en stays 0.
- **Alias/replacement:** confident entry at 0x100, then taken backward branch at 0x200 (same index, different tag) -> three aging hits drop conf 3→0. The fourth allocates 0x200, after which 0x100 misses.
- **Flush:** confident loop with F 2 iterations ahead of EX, flush_EX=1 -> spec_iter equals commit_iter next cycle and predictions resume correctly. Flush in the same cycle as an F hit on that entry -> flush value wins.
